data_mem_block_responder: RTL
=============================

Name: data_mem_block_responder

Overview:
- Main-memory responder on the cache-refill/writeback bus.
- Serves 128-bit block reads and writes issued by the data cache controller; a busywait handshake holds the requester for a fixed, parameterised access latency.
- Sits below the data cache in the RV32IM pipeline memory hierarchy.
- Backed by an internal block array.

Parameters:
- INDEX_BITS, 6, number of address LSBs used to index storage (2^INDEX_BITS blocks of 128 bits). Range 1..12.
- LATENCY, 5, posedge count spent in BUSY before the access commits. Range 1..255.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- read  in  1  block read request, held until busywait is sampled low.
- write  in  1  block write request, held until busywait is sampled low.
- address  in  28  block address ({tag,index} from the cache); bits [27:INDEX_BITS] ignored (aliasing).
- writedata  in  128  block to store.
- readdata  out  128  block returned; valid in the DONE cycle.
- busywait  out  1  high while a request is pending and not complete.

Behaviour:
- States: IDLE, BUSY, DONE. Down-counter cnt is 8 bits.
- Reset (reset=0, async):
  - state=IDLE, cnt=0, readdata=0, latched address/data/op cleared.
  - Storage contents are not cleared.
  - Reset mid-operation abandons the access: no array write, busywait low while reset=0.
- busywait is combinational: (read|write) && state!=DONE. It rises in the same cycle the request appears.
- IDLE, posedge with read|write:
  - Latch address[INDEX_BITS-1:0], writedata, op (write has priority if both are high).
  - cnt=LATENCY-1; go to BUSY.
- BUSY, each posedge:
  - If read|write has dropped: abort to IDLE with no commit.
  - Else if cnt==0: commit and go to DONE.
  - Else decrement cnt.
- Commit:
  - Write: array[idx]=latched data; readdata unchanged.
  - Read: readdata<=array[idx].
- DONE:
  - busywait=0 for exactly one cycle. The requester samples !busywait at the closing posedge and captures readdata.
  - Next posedge returns to IDLE unconditionally.
  - A request still held in the following IDLE cycle is treated as a new access.
- Latency: request seen before posedge k → busywait low during the cycle after posedge k+LATENCY. Total busy cycles = LATENCY+1.
- Address and writedata changes after acceptance are ignored; the latched copies are used.
- read and write both high: performs a write only.
- readdata holds its last read value outside DONE.
- X on read/write: busywait driven 0 and no request is accepted (matches the cache's undefined-state handling).

Optional Feature:
- Macro: DATA_MEM_STATS_EN.
- Defined:
  - Adds outputs read_count[31:0] and write_count[31:0].
  - Each increments by 1 on a committed read or write, saturating at 32'hFFFF_FFFF.
  - Aborted accesses are not counted.
  - Both reset to 0 on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package data_mem_pkg:
  - state enum {IDLE,BUSY,DONE}.
  - BLOCK_W=128, BLOCK_ADDR_W=28.
  - Op encoding {OP_READ,OP_WRITE}.
- Sub-module data_mem_block_array:
  - Single-port 2^INDEX_BITS x 128 storage.
  - Synchronous write enable, registered read into readdata.
  - Keeps the FSM free of array inference details.

Test Plan:
- Reset with read=1 held: busywait=0 and readdata=0 while reset=0. After release, busywait goes high in the same cycle; DONE occurs LATENCY+1 cycles later.
- Write addr=28'h000_0003, data=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D (LATENCY=5) → busywait high 6 cycles then low 1 cycle; readdata unchanged. Then read the same addr → same 128-bit value during DONE.
- Aliasing: write addr 28'h40 with INDEX_BITS=6, read addr 28'h0 → returns the written block.
- Abort: read accepted, read dropped at cnt=2 → IDLE next edge, no DONE pulse, readdata unchanged. Write aborted likewise → array is not modified.
- Async reset asserted mid-BUSY on a write → busywait=0 immediately; a subsequent read returns the old contents.
- Back-to-back writeback then refill (write addr A, then read addr B without an idle gap) → two independent busy windows; B data correct. With DATA_MEM_STATS_EN: write_count=1, read_count=1.

Source files
------------

// File: rtl/data_mem_block_responder_pkg.sv
// Shared types and widths for the block-level main-memory responder.
package data_mem_pkg;

  localparam int BLOCK_W      = 128;
  localparam int BLOCK_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

endpackage

// File: rtl/data_mem_block_responder_if.sv
// Cache-refill/writeback bus between the data cache controller (master) and main memory (slave).
interface data_mem_block_responder_if;
  import data_mem_pkg::*;

  logic                    read;
  logic                    write;
  logic [BLOCK_ADDR_W-1:0] address;
  logic [BLOCK_W-1:0]      writedata;
  logic [BLOCK_W-1:0]      readdata;
  logic                    busywait;
`ifdef DATA_MEM_STATS_EN
  logic [31:0]             read_count;
  logic [31:0]             write_count;
`endif

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
`ifdef DATA_MEM_STATS_EN
    , input read_count, write_count
`endif
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
`ifdef DATA_MEM_STATS_EN
    , output read_count, write_count
`endif
  );

endinterface

// File: rtl/data_mem_block_responder_array.sv
// Single-port 2^INDEX_BITS x 128 block store: synchronous write, registered read port.
// Storage itself is never reset; only the read register is.
module data_mem_block_array
  import data_mem_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [INDEX_BITS-1:0] idx_i,
  input  logic [BLOCK_W-1:0]    wdata_i,
  output logic [BLOCK_W-1:0]    rdata_o
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [BLOCK_W-1:0] rdata_q;
  logic [BLOCK_W-1:0] rdata_d;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[idx_i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_block_responder.sv
// Main-memory block responder: IDLE/BUSY/DONE busywait handshake, commit after LATENCY edges in BUSY.
// Optional read/write commit counters when DATA_MEM_STATS_EN is defined.
module data_mem_block_responder
  import data_mem_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int LATENCY    = 5
) (
  input logic                       clock,
  input logic                       reset,
  data_mem_block_responder_if.slave bus
);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0]      wdata_q, wdata_d;
  op_e                     op_q, op_d;
  logic                    req;
  logic                    commit_we;
  logic                    commit_re;
  logic                    unused_addr_bits;

  assign req              = bus.read | bus.write;
  assign unused_addr_bits = ^bus.address[BLOCK_ADDR_W-1:INDEX_BITS];

  // Written as an if so an unknown request resolves to "not busy" rather than X.
  always_comb begin
    bus.busywait = 1'b0;
    if (reset && req && (state_q != DONE)) begin
      bus.busywait = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    commit_we = 1'b0;
    commit_re = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = bus.address[INDEX_BITS-1:0];
          wdata_d = bus.writedata;
          op_d    = bus.write ? OP_WRITE : OP_READ;
          cnt_d   = 8'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          commit_we = (op_q == OP_WRITE);
          commit_re = (op_q == OP_READ);
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
    end
  end

  data_mem_block_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clock  (clock),
    .reset  (reset),
    .we_i   (commit_we),
    .re_i   (commit_re),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(bus.readdata)
  );

`ifdef DATA_MEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Saturate rather than wrap so a long soak never reports a tiny count.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (commit_re && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
    if (commit_we && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.read_count  = rd_cnt_q;
  assign bus.write_count = wr_cnt_q;
`endif

endmodule
